// File: rtl/calc_pkg.sv
// calc_pkg: shared state encoding, key codes and defaults for the calculator sequencer
package calc_pkg;
  typedef enum logic [2:0] {S_A, S_SIGN, S_B, S_START, S_WAIT, S_SHOW} state_e;
  localparam logic [3:0] KEY_MUL = 4'hA;
  localparam logic [3:0] KEY_EQ  = 4'hB;
  localparam logic [3:0] KEY_CLR = 4'hC;
  localparam logic [3:0] KEY_NEG = 4'hD;
  localparam int DIGIT_MAX = 3;
  function automatic logic is_digit(input logic [3:0] k);
    return k <= 4'd9;
  endfunction
endpackage

// File: rtl/calc_sequencer_if.sv
// calc_sequencer_if: keypad, multiplier handshake and storage-enable signals of the sequencer
interface calc_sequencer_if;
  logic [3:0] key_value;
  logic key_pressed, mul_done;
  logic enable_A, enable_sign, enable_B, load_digit, clear_entry;
  logic neg_A, neg_B, mul_start, valid, error;
  modport master (
    input  key_value, key_pressed, mul_done,
    output enable_A, enable_sign, enable_B, load_digit, clear_entry, neg_A, neg_B, mul_start, valid, error
  );
  modport slave (
    output key_value, key_pressed, mul_done,
    input  enable_A, enable_sign, enable_B, load_digit, clear_entry, neg_A, neg_B, mul_start, valid, error
  );
endinterface

// File: rtl/key_edge_detect.sv
// key_edge_detect: one event per debounced key press from a registered previous level
module key_edge_detect (
  input  logic clk,
  input  logic rst,
  input  logic key_pressed_i,
  output logic key_event_o
);
  logic prev_q;
  always_ff @(posedge clk) prev_q <= rst ? 1'b0 : key_pressed_i;
  assign key_event_o = key_pressed_i & ~prev_q;
endmodule

// File: rtl/calc_sequencer.sv
// calc_sequencer: keypad operand entry and Booth multiply sequencing; SEQ_TIMEOUT_EN adds a multiplier watchdog
module calc_sequencer
  import calc_pkg::*;
#(
  parameter int MAX_DIGITS = DIGIT_MAX
`ifdef SEQ_TIMEOUT_EN
  , parameter int TIMEOUT_CYC = 1024
`endif
) (
  input logic clk,
  input logic rst,
  calc_sequencer_if.master io
);
  localparam int DW = $clog2(MAX_DIGITS + 1);
  state_e state_q, state_d;
  logic [DW-1:0] dcnt_q, dcnt_d;
  logic neg_a_q, neg_a_d, neg_b_q, neg_b_d, valid_q, valid_d, error_q, error_d;
  logic load_q, load_d, clr_q, clr_d;
  logic ev, tmo, clr_key, entry;
  logic [3:0] k;
  key_edge_detect u_edge (.clk(clk), .rst(rst), .key_pressed_i(io.key_pressed), .key_event_o(ev));
`ifdef SEQ_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  logic [TW-1:0] tcnt_q;
  always_ff @(posedge clk) tcnt_q <= (rst || state_q != S_WAIT) ? '0 : tcnt_q + 1'b1;
  assign tmo = tcnt_q == TW'(TIMEOUT_CYC - 1);
`else
  assign tmo = 1'b0;
`endif
  assign k = io.key_value;
  assign entry = state_q == S_A || state_q == S_B;
  assign clr_key = ev && k == KEY_CLR && (entry || state_q == S_SIGN || state_q == S_SHOW);
  always_comb begin
    state_d = state_q;
    dcnt_d  = dcnt_q;
    neg_a_d = neg_a_q;
    neg_b_d = neg_b_q;
    valid_d = valid_q;
    error_d = error_q;
    load_d  = 1'b0;
    clr_d   = 1'b0;
    if (clr_key) begin
      state_d = S_A;
      dcnt_d  = '0;
      neg_a_d = 1'b0;
      neg_b_d = 1'b0;
      valid_d = 1'b0;
      error_d = 1'b0;
      clr_d   = 1'b1;
    end else if (entry) begin
      if (ev && is_digit(k) && dcnt_q < DW'(MAX_DIGITS)) begin
        load_d = 1'b1;
        dcnt_d = dcnt_q + 1'b1;
      end
      if (ev && k == KEY_NEG) begin
        neg_a_d = neg_a_q ^ (state_q == S_A);
        neg_b_d = neg_b_q ^ (state_q == S_B);
      end
      if (ev && dcnt_q != '0 && k == (state_q == S_A ? KEY_MUL : KEY_EQ))
        state_d = state_q == S_A ? S_SIGN : S_START;
    end else if (state_q == S_SIGN) begin
      dcnt_d  = '0;
      state_d = S_B;
    end else if (state_q == S_START) begin
      state_d = S_WAIT;
    end else if (state_q == S_WAIT && (io.mul_done || tmo)) begin
      state_d = S_SHOW;
      valid_d = io.mul_done;
      error_d = ~io.mul_done;
    end
  end
  always_ff @(posedge clk)
    if (rst) begin
      state_q <= S_A;
      dcnt_q  <= '0;
      neg_a_q <= 1'b0;
      neg_b_q <= 1'b0;
      valid_q <= 1'b0;
      error_q <= 1'b0;
      load_q  <= 1'b0;
      clr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      dcnt_q  <= dcnt_d;
      neg_a_q <= neg_a_d;
      neg_b_q <= neg_b_d;
      valid_q <= valid_d;
      error_q <= error_d;
      load_q  <= load_d;
      clr_q   <= clr_d;
    end
  assign io.enable_A    = state_q == S_A;
  assign io.enable_sign = state_q == S_SIGN;
  assign io.enable_B    = state_q == S_B;
  assign io.mul_start   = state_q == S_START;
  assign io.load_digit  = load_q;
  assign io.clear_entry = clr_q;
  assign io.neg_A       = neg_a_q;
  assign io.neg_B       = neg_b_q;
  assign io.valid       = valid_q;
  assign io.error       = error_q;
endmodule

// File: tb/tb_calc_sequencer.sv
// tb_calc_sequencer: directed self-checking bench for calc_sequencer
module tb_calc_sequencer;
  import calc_pkg::*;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int errors = 0;
  int n_load = 0, n_sign = 0, n_start = 0;
  int l0, s0, m0;
  calc_sequencer_if io();
`ifdef SEQ_TIMEOUT_EN
  calc_sequencer #(.TIMEOUT_CYC(16)) dut (.clk(clk), .rst(rst), .io(io));
`else
  calc_sequencer dut (.clk(clk), .rst(rst), .io(io));
`endif
  always #5 clk = ~clk;
  always @(posedge clk) begin
    if (io.load_digit) n_load++;
    if (io.enable_sign) n_sign++;
    if (io.mul_start) n_start++;
  end
  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask
  task automatic chk_idle(input string tag);
    chk({tag, "_outs"}, int'({io.enable_A, io.enable_sign, io.enable_B, io.load_digit, io.clear_entry,
        io.neg_A, io.neg_B, io.mul_start, io.valid, io.error}), int'(10'b1000000000));
    chk({tag, "_state"}, int'(dut.state_q), int'(S_A));
    chk({tag, "_dcnt"}, int'(dut.dcnt_q), 0);
  endtask
  task automatic press(input logic [3:0] kv);
    @(negedge clk);
    io.key_value = kv;
    io.key_pressed = 1'b1;
    @(negedge clk);
    io.key_pressed = 1'b0;
  endtask
  initial begin
    io.key_value = 4'h0;
    io.key_pressed = 1'b0;
    io.mul_done = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk_idle("reset");
    l0 = n_load;
    press(4'h9);
    chk("load_pulse_hi", int'(io.load_digit), 1);
    press(4'h9);
    press(4'h9);
    press(4'h9);
    chk("load_after_4th", int'(io.load_digit), 0);
    @(negedge clk);
    chk("nine_loads", n_load - l0, 3);
    chk("nine_dcnt", int'(dut.dcnt_q), 3);
    press(KEY_CLR);
    chk("clr_pulse", int'(io.clear_entry), 1);
    chk("clr_dcnt", int'(dut.dcnt_q), 0);
    @(negedge clk);
    chk("clr_width", int'(io.clear_entry), 0);
    press(KEY_MUL);
    chk("mul_no_digit", int'(dut.state_q), int'(S_A));
    press(KEY_EQ);
    chk("eq_in_a", int'(dut.state_q), int'(S_A));
    press(KEY_NEG);
    chk("neg_a_once", int'(io.neg_A), 1);
    press(KEY_NEG);
    press(4'h5);
    chk("neg_a_twice", int'(io.neg_A), 0);
    chk("dcnt_after_5", int'(dut.dcnt_q), 1);
    press(KEY_CLR);
    @(negedge clk);
    chk_idle("clear2");
    l0 = n_load; s0 = n_sign; m0 = n_start;
    press(4'h1);
    press(4'h2);
    press(KEY_MUL);
    chk("sign_state", int'(io.enable_sign), 1);
    press(KEY_NEG);
    chk("neg_b", int'(io.neg_B), 1);
    chk("neg_a_kept", int'(io.neg_A), 0);
    press(4'h3);
    chk("enable_b", int'(io.enable_B), 1);
    press(4'h4);
    press(KEY_EQ);
    chk("mul_start", int'(io.mul_start), 1);
    @(negedge clk);
    io.key_value = KEY_CLR;
    io.key_pressed = 1'b1;
    @(negedge clk);
    io.key_pressed = 1'b0;
    chk("clr_in_wait_state", int'(dut.state_q), int'(S_WAIT));
    chk("clr_in_wait_pulse", int'(io.clear_entry), 0);
    repeat (3) @(negedge clk);
    io.mul_done = 1'b1;
    chk("valid_before", int'(io.valid), 0);
    @(negedge clk);
    io.mul_done = 1'b0;
    chk("valid_after", int'(io.valid), 1);
    chk("show_state", int'(dut.state_q), int'(S_SHOW));
    chk("show_enables", int'({io.enable_A, io.enable_sign, io.enable_B}), 0);
    chk("main_loads", n_load - l0, 4);
    chk("main_sign_cyc", n_sign - s0, 1);
    chk("main_starts", n_start - m0, 1);
    press(4'h5);
    chk("digit_in_show", int'({io.load_digit, io.valid}), 1);
    press(KEY_CLR);
    chk("clr_show_pulse", int'(io.clear_entry), 1);
    chk("clr_show_state", int'(dut.state_q), int'(S_A));
    chk("clr_show_valid", int'(io.valid), 0);
    chk("clr_show_negb", int'(io.neg_B), 0);
    l0 = n_load;
    @(negedge clk);
    io.key_value = 4'h7;
    io.key_pressed = 1'b1;
    repeat (50) @(negedge clk);
    io.key_pressed = 1'b0;
    @(negedge clk);
    chk("held_loads", n_load - l0, 1);
    chk("held_dcnt", int'(dut.dcnt_q), 1);
    press(KEY_MUL);
    press(4'h3);
    press(KEY_EQ);
    @(negedge clk);
    chk("rst_pre_wait", int'(dut.state_q), int'(S_WAIT));
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk_idle("mid_rst");
    io.mul_done = 1'b1;
    @(negedge clk);
    io.mul_done = 1'b0;
    @(negedge clk);
    chk_idle("late_done");
`ifdef SEQ_TIMEOUT_EN
    press(4'h2);
    press(KEY_MUL);
    press(4'h3);
    press(KEY_EQ);
    chk("tmo_start", int'(io.mul_start), 1);
    repeat (16) @(negedge clk);
    chk("tmo_still_wait", int'(dut.state_q), int'(S_WAIT));
    @(negedge clk);
    chk("tmo_state", int'(dut.state_q), int'(S_SHOW));
    chk("tmo_error", int'(io.error), 1);
    chk("tmo_valid", int'(io.valid), 0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk_idle("tmo_rst");
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
